// File: rtl/mod_multiply.sv
// Modular multiplier: result = (a*b) mod n by MSB-first shift-and-add,
// one multiplier bit per clock, with an operand range check at start.
module mod_multiply #(
    parameter int unsigned RSA_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [RSA_WIDTH-1:0] a,
    input  logic [RSA_WIDTH-1:0] b,
    input  logic [RSA_WIDTH-1:0] n,
    output logic [RSA_WIDTH-1:0] result,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned W     = RSA_WIDTH;
    localparam int unsigned EW    = RSA_WIDTH + 1;
    localparam int unsigned CNT_W = (RSA_WIDTH > 1) ? $clog2(RSA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     n_q;
    logic [W-1:0]     r_q;
    logic [CNT_W-1:0] cnt_q;

    logic             range_bad_c;
    logic             bit_c;
    logic [EW-1:0]    n_ext_c;
    logic [EW-1:0]    dbl_c;
    logic [EW-1:0]    dbl_red_c;
    logic [EW-1:0]    sum_c;
    logic [EW-1:0]    sum_red_c;
    logic [W-1:0]     r_step_c;

    // One shift-and-add step on the latched operands, one extra bit of headroom
    always_comb begin
        range_bad_c = (a >= n) || (b >= n);
        bit_c       = b_q[cnt_q];
        n_ext_c     = {1'b0, n_q};
        dbl_c       = {r_q, 1'b0};
        dbl_red_c   = (dbl_c >= n_ext_c) ? (dbl_c - n_ext_c) : dbl_c;
        sum_c       = bit_c ? (dbl_red_c + {1'b0, a_q}) : dbl_red_c;
        sum_red_c   = (sum_c >= n_ext_c) ? (sum_c - n_ext_c) : sum_c;
        r_step_c    = sum_red_c[W-1:0];
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = range_bad_c ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch, accumulator, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            busy <= (state_next == BUSY);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        n_q   <= n;
                        r_q   <= '0;
                        cnt_q <= CNT_W'(W - 1);
                        err   <= range_bad_c;
                    end
                end
                BUSY: begin
                    r_q   <= r_step_c;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                DONE: begin
                    result <= r_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mod_multiply.md
MOD_MULTIPLY -- requirements
Module: mod_multiply

Interface
REQ-001 The block SHALL have parameter RSA_WIDTH, default 128, giving the operand, modulus and result width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 Port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 Port a, input, RSA_WIDTH bits: multiplicand.
REQ-006 Port b, input, RSA_WIDTH bits: multiplier.
REQ-007 Port n, input, RSA_WIDTH bits: modulus.
REQ-008 Port result, output, RSA_WIDTH bits: (a*b) mod n.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 Port busy, output, 1 bit: high while an operation is in progress.
REQ-011 Port err, output, 1 bit: operand-range violation flag for the last operation.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch a, b and n into internal registers; later input changes SHALL NOT affect the operation.
REQ-014 Range check at start: if a>=n or b>=n (this includes n=0), the next state SHALL be DONE, with result=0 and err=1; no iterations SHALL run.
REQ-015 Otherwise the block SHALL clear err, clear the accumulator r, load the bit counter with RSA_WIDTH-1, and go to BUSY.
REQ-016 Each BUSY cycle SHALL process one bit of latched b, MSB first:
- t = 2r; if t>=n then t = t-n;
- if the bit is 1, t = t+a; if t>=n then t = t-n;
- r = t.
REQ-017 The datapath SHALL use RSA_WIDTH+1 bits internally so that 2r and r+a never overflow; r SHALL always stay below n.
REQ-018 BUSY SHALL last exactly RSA_WIDTH cycles; after the bit-0 cycle the next state SHALL be DONE.
REQ-019 On entry to DONE, result SHALL load r and done SHALL be 1 for that one cycle; the next state SHALL be IDLE.
REQ-020 Latency, valid operands: start sampled at edge k gives done=1 during the cycle after edge k+RSA_WIDTH+1.
REQ-021 Latency, range error: done=1 during the cycle after edge k+1.
REQ-022 busy SHALL equal 1 exactly while the state is BUSY.
REQ-023 start SHALL be ignored in BUSY and in DONE.
REQ-024 A start held high SHALL begin a new operation on the first IDLE cycle.
REQ-025 result and err SHALL hold their values until the next accepted start changes them.
REQ-026 n=1 with a=b=0 SHALL yield result=0, err=0 after the full latency.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL go to IDLE and force result=0, done=0, busy=0, err=0.
REQ-028 Reset SHALL clear r and the bit counter.
REQ-029 Reset SHALL take priority over start and over any in-progress operation.
REQ-030 After reset deasserts, the block SHALL accept start on the first following edge.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- RSA_WIDTH=8; a=7, b=9, n=13, start pulse -> done after 9 cycles, result=11, err=0, busy high for exactly 8 cycles.
- RSA_WIDTH=128; a=3, b=5, n=7 -> result=1 after 129 cycles; then a=2^127-2, b=2, n=2^127-1 -> result=2^127-3 (no overflow).
- RSA_WIDTH=8; a=13, b=2, n=13 -> done on the next cycle, err=1, result=0; then n=0 with a=b=0 -> err=1.
- RSA_WIDTH=8; a=5, b=6, n=11, start pulses every cycle during BUSY, and a/b/n changed mid-operation -> single done, result=8.
- RSA_WIDTH=8; reset asserted 4 cycles into BUSY -> busy=0, done never pulses, result=0; a new start then yields a correct result.
- RSA_WIDTH=8; start held high for 30 cycles with a=4, b=4, n=5 -> done pulses every 10 cycles, result=1 each time.
